// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C request sequencer.
// Command entry layout, FSM states and bus bit positions.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_FINISH
  } seq_state_e;

  localparam int unsigned BITS_PER_XFER = 18;
  localparam int unsigned ADDR_ACK_BIT  = 9;

  localparam int unsigned CMD_DATA_W = 8;
  localparam int unsigned CMD_ADDR_W = 7;

  typedef struct packed {
    logic                  op;
    logic                  restart;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_request_sequencer_fifo.sv
// Synchronous command FIFO with occupancy count.
// Full is derived from the registered count, so a pop frees a slot next cycle.
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         wr_data,
  input  logic                     pop,
  output T                         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T             mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (!do_push && do_pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2c_request_sequencer.sv
// Command sequencer in front of the I2C core: queues host commands,
// issues them one at a time and tracks completion from the observed bus.
module i2c_request_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_restart,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] controller_data_req,
  output logic [ADDR_WIDTH-1:0] controller_addr_req,
  output logic                  controller_operation_req,
  output logic                  controller_restart_req,
  output logic                  controller_valid_req,
  output logic                  error_signal,
  input  logic [DATA_WIDTH-1:0] controller_data_rsp,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  busy
);

  typedef struct packed {
    logic                  op;
    logic                  restart;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  entry_t        wr_entry;
  entry_t        rd_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  assign wr_entry = '{op: cmd_op, restart: cmd_restart,
                      addr: cmd_addr, data: cmd_data};

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .wr_data (wr_entry),
    .pop     (fifo_pop),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  // Idle bus is high, so sync flops reset to 1 to avoid a phantom edge.
  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_p_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_p_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_p_q  <= sda_s2_q;
    end
  end

  logic scl_rise;
  logic start_det;
  logic stop_det;
  logic bus_edge;

  assign scl_rise  = scl_s2_q && !scl_p_q;
  assign start_det = scl_s2_q && scl_p_q && sda_p_q && !sda_s2_q;
  assign stop_det  = scl_s2_q && scl_p_q && !sda_p_q && sda_s2_q;
  assign bus_edge  = (scl_s2_q ^ scl_p_q) | (sda_s2_q ^ sda_p_q);

  seq_state_e            state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_q, err_d;
  logic                  req_op_q, req_op_d;
  logic                  req_rst_q, req_rst_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_vld_q, req_vld_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_sig_q, err_sig_d;
  logic                  complete;
  logic                  active;
  logic                  timeout;
  logic [4:0]            bit_nxt;

  assign active  = (state_q != S_IDLE);
  assign timeout = active && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign bit_nxt = bit_cnt_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    err_d      = err_q;
    req_op_d   = req_op_q;
    req_rst_d  = req_rst_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_vld_d  = req_vld_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    err_sig_d  = 1'b0;
    fifo_pop   = 1'b0;
    complete   = 1'b0;
    timer_d    = '0;

    if (timeout) begin
      err_sig_d = 1'b1;
      rsp_vld_d = 1'b1;
      rsp_err_d = 1'b1;
      req_vld_d = 1'b0;
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            req_op_d   = rd_entry.op;
            req_rst_d  = rd_entry.restart;
            req_addr_d = rd_entry.addr;
            req_data_d = rd_entry.data;
            req_vld_d  = 1'b1;
            err_d      = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_REQ: begin
          if (start_det) begin
            bit_cnt_d = '0;
            state_d   = S_XFER;
          end
        end
        S_XFER: begin
          if (scl_rise) begin
            bit_cnt_d = bit_nxt;
            if (bit_nxt == 5'(ADDR_ACK_BIT) && sda_s2_q) begin
              err_sig_d = 1'b1;
              err_d     = 1'b1;
              req_vld_d = 1'b0;
              state_d   = S_FINISH;
            end else if (bit_nxt == 5'(BITS_PER_XFER)) begin
              if (req_rst_q) complete = 1'b1;
              else           state_d  = S_FINISH;
            end
          end
        end
        S_FINISH: begin
          if (stop_det) complete = 1'b1;
        end
      endcase

      if (complete) begin
        rsp_vld_d  = 1'b1;
        rsp_err_d  = err_q;
        rsp_data_d = (req_op_q && !err_q) ? controller_data_rsp : '0;
        req_vld_d  = 1'b0;
        state_d    = S_IDLE;
      end
    end

    // Any bus activity or state change restarts the watchdog.
    if (active && (state_d == state_q) && !bus_edge)
      timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      req_op_q   <= 1'b0;
      req_rst_q  <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_vld_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_sig_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      req_op_q   <= req_op_d;
      req_rst_q  <= req_rst_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_vld_q  <= req_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      err_sig_q  <= err_sig_d;
    end
  end

  assign controller_data_req      = req_data_q;
  assign controller_addr_req      = req_addr_q;
  assign controller_operation_req = req_op_q;
  assign controller_restart_req   = req_rst_q;
  assign controller_valid_req     = req_vld_q;
  assign rsp_valid                = rsp_vld_q;
  assign rsp_data                 = rsp_data_q;
  assign rsp_error                = rsp_err_q;
  assign error_signal             = err_sig_q;
  assign busy = active || (fifo_count != '0);

endmodule

// File: tb/tb_i2c_request_sequencer.sv
// Directed bench for i2c_request_sequencer with a simple bus driver.
// Responses and error pulses are logged at negedge and checked inline.
module tb_i2c_request_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 7;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_restart;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic [DW-1:0] data_req;
  logic [AW-1:0] addr_req;
  logic          op_req;
  logic          rst_req;
  logic          vld_req;
  logic          error_signal;
  logic [DW-1:0] data_rsp;
  logic          scl;
  logic          sda;
  logic          busy;

  always #5 clk = ~clk;

  i2c_request_sequencer #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_op                   (cmd_op),
    .cmd_addr                 (cmd_addr),
    .cmd_data                 (cmd_data),
    .cmd_restart              (cmd_restart),
    .rsp_valid                (rsp_valid),
    .rsp_data                 (rsp_data),
    .rsp_error                (rsp_error),
    .controller_data_req      (data_req),
    .controller_addr_req      (addr_req),
    .controller_operation_req (op_req),
    .controller_restart_req   (rst_req),
    .controller_valid_req     (vld_req),
    .error_signal             (error_signal),
    .controller_data_rsp      (data_rsp),
    .scl_in                   (scl),
    .sda_in                   (sda),
    .busy                     (busy)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          rst;
    logic          vreq;
    logic          vprev;
    int            cyc;
  } ev_t;

  ev_t  rq[$];
  ev_t  eq[$];
  int   vrise[$];
  int   cyc = 0;
  logic vprev = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic ev_t mk_ev();
    ev_t e;
    e.err   = rsp_error;
    e.data  = rsp_data;
    e.addr  = addr_req;
    e.rst   = rst_req;
    e.vreq  = vld_req;
    e.vprev = vprev;
    e.cyc   = cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) rq.push_back(mk_ev());
    if (error_signal) eq.push_back(mk_ev());
    if (vld_req && !vprev) vrise.push_back(cyc);
    vprev <= vld_req;
    cyc   <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic get_rsp(input string tag, output ev_t e);
    chk({tag, "_present"}, 32'(rq.size() != 0), 1);
    if (rq.size() != 0) e = rq.pop_front();
    else e = '{default: '0};
  endtask

  task automatic get_err(input string tag, output ev_t e);
    chk({tag, "_present"}, 32'(eq.size() != 0), 1);
    if (eq.size() != 0) e = eq.pop_front();
    else e = '{default: '0};
  endtask

  task automatic push_cmd(input logic op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic rs);
    cmd_op      = op;
    cmd_addr    = a;
    cmd_data    = d;
    cmd_restart = rs;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  // START, 18 clocked bits (ACK at 9 and 18), optional STOP.
  task automatic bus_txn(input logic nack9, input logic do_stop);
    scl = 1'b0; wait_n(3);
    sda = 1'b1; wait_n(3);
    scl = 1'b1; wait_n(4);
    sda = 1'b0; wait_n(3);
    for (int b = 1; b <= 18; b++) begin
      scl = 1'b0; wait_n(2);
      if (b == 9)       sda = nack9;
      else if (b == 18) sda = 1'b0;
      else              sda = b[0];
      wait_n(2);
      scl = 1'b1; wait_n(3);
    end
    if (do_stop) begin
      scl = 1'b0; wait_n(2);
      sda = 1'b0; wait_n(2);
      scl = 1'b1; wait_n(3);
      sda = 1'b1; wait_n(6);
    end else begin
      wait_n(3);
    end
  endtask

  initial begin
    ev_t r, e;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_addr = '0; cmd_data = '0; cmd_restart = 1'b0;
    data_rsp = '0; scl = 1'b1; sda = 1'b1;
    wait_n(3);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_vreq", 32'(vld_req), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_errsig", 32'(error_signal), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(addr_req), 0);
    rst_n = 1'b1;
    wait_n(2);

    // write 0xA5 to 0x10
    push_cmd(1'b0, 7'h10, 8'hA5, 1'b0);
    chk("w_vreq_lat0", 32'(vld_req), 0);
    tick();
    chk("w_vreq_lat1", 32'(vld_req), 1);
    chk("w_addr", 32'(addr_req), 32'h10);
    chk("w_data", 32'(data_req), 32'hA5);
    chk("w_op", 32'(op_req), 0);
    bus_txn(1'b0, 1'b1);
    wait_n(2);
    get_rsp("w_rsp", r);
    chk("w_rsp_err", 32'(r.err), 0);
    chk("w_rsp_data", 32'(r.data), 0);
    chk("w_vreq_held", 32'(r.vprev), 1);
    chk("w_vreq_drop", 32'(r.vreq), 0);

    // read 0x3C from 0x10
    data_rsp = 8'h3C;
    push_cmd(1'b1, 7'h10, 8'h00, 1'b0);
    wait_n(2);
    chk("r_op", 32'(op_req), 1);
    bus_txn(1'b0, 1'b1);
    wait_n(2);
    get_rsp("r_rsp", r);
    chk("r_rsp_data", 32'(r.data), 32'h3C);
    chk("r_rsp_err", 32'(r.err), 0);

    // address NACK
    push_cmd(1'b0, 7'h22, 8'h5A, 1'b0);
    wait_n(2);
    bus_txn(1'b1, 1'b1);
    wait_n(2);
    get_err("n_err", e);
    chk("n_err_cnt", 32'(eq.size()), 0);
    chk("n_vreq_drop", 32'(e.vreq), 0);
    get_rsp("n_rsp", r);
    chk("n_rsp_err", 32'(r.err), 1);
    chk("n_rsp_data", 32'(r.data), 0);
    chk("n_rsp_after_stop", 32'((r.cyc - e.cyc) > 20), 1);

    // timeout with an idle bus
    vrise.delete();
    data_rsp = 8'h77;
    push_cmd(1'b1, 7'h33, 8'h00, 1'b0);
    wait_n(60);
    get_err("t_err", e);
    get_rsp("t_rsp", r);
    chk("t_rsp_err", 32'(r.err), 1);
    chk("t_rsp_data", 32'(r.data), 0);
    chk("t_same_cyc", 32'(r.cyc - e.cyc), 0);
    chk("t_vrise_cnt", 32'(vrise.size()), 1);
    if (vrise.size() != 0)
      chk("t_latency", 32'(e.cyc - vrise[0]), TO);
    chk("t_vreq", 32'(vld_req), 0);
    chk("t_busy", 32'(busy), 0);

    // restart write then read
    vrise.delete();
    push_cmd(1'b0, 7'h44, 8'h12, 1'b1);
    push_cmd(1'b1, 7'h45, 8'h00, 1'b0);
    wait_n(2);
    chk("rs_rst_req", 32'(rst_req), 1);
    data_rsp = 8'h9E;
    bus_txn(1'b0, 1'b0);
    wait_n(4);
    get_rsp("rs_rsp1", r);
    chk("rs1_addr", 32'(r.addr), 32'h44);
    chk("rs1_err", 32'(r.err), 0);
    chk("rs1_rst", 32'(r.rst), 1);
    chk("rs_vrise_cnt", 32'(vrise.size()), 2);
    if (vrise.size() > 1)
      chk("rs_gap", 32'(vrise[1] - r.cyc), 1);
    chk("rs2_rst_req", 32'(rst_req), 0);
    bus_txn(1'b0, 1'b1);
    wait_n(2);
    get_rsp("rs_rsp2", r);
    chk("rs2_addr", 32'(r.addr), 32'h45);
    chk("rs2_data", 32'(r.data), 32'h9E);

    // fill FIFO behind an in-flight write
    push_cmd(1'b0, 7'h01, 8'h11, 1'b0);
    wait_n(3);
    for (int i = 0; i < 5; i++) begin
      cmd_op      = i[0];
      cmd_addr    = 7'h20 + 7'(i);
      cmd_data    = 8'hB0 + 8'(i);
      cmd_restart = 1'b0;
      cmd_valid   = 1'b1;
      chk("f_ready", 32'(cmd_ready), 32'(i < 4));
      if (i < 4) tick();
    end
    wait_n(3);
    chk("f_held", 32'(cmd_ready), 0);
    data_rsp = 8'h00;
    bus_txn(1'b0, 1'b1);
    wait_n(4);
    cmd_valid = 1'b0;
    chk("f_refull", 32'(cmd_ready), 0);
    get_rsp("f_rsp0", r);
    chk("f0_addr", 32'(r.addr), 32'h01);
    for (int i = 0; i < 5; i++) begin
      data_rsp = 8'hC0 + 8'(i);
      bus_txn(1'b0, 1'b1);
      wait_n(2);
      get_rsp("f_rsp", r);
      chk("f_addr", 32'(r.addr), 32'h20 + 32'(i));
      chk("f_data", 32'(r.data), i[0] ? 32'hC0 + 32'(i) : 0);
    end
    chk("f_busy", 32'(busy), 0);

    // reset mid-transaction
    push_cmd(1'b0, 7'h55, 8'h66, 1'b0);
    wait_n(2);
    chk("mr_vreq_on", 32'(vld_req), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_vreq_off", 32'(vld_req), 0);
    tick();
    rst_n = 1'b1;
    wait_n(5);
    chk("mr_no_rsp", 32'(rq.size()), 0);
    chk("mr_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_request_sequencer.md
Name: i2c_request_sequencer

Overview:
Upstream command stage for the I2C core. Buffers host transactions in a small FIFO and drives the core's controller request inputs one transaction at a time. Observes the SCL/SDA bus to decide when each transaction is complete. Returns a read result or error status per command, and raises error_signal on NACK or bus timeout.

Parameters:
DATA_WIDTH, 8, data byte width
ADDR_WIDTH, 7, target address width
FIFO_DEPTH, 4, command FIFO entries (power of two, at least 2)
TIMEOUT_CYCLES, 2000, clk cycles with no observed bus edge before abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmd_valid  in  1  host command present
cmd_ready  out  1  FIFO not full
cmd_op  in  1  0 = write, 1 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_data  in  DATA_WIDTH  write byte
cmd_restart  in  1  end with repeated START instead of STOP
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_WIDTH  read byte; 0 for writes
rsp_error  out  1  qualifies rsp_valid: NACK or timeout
controller_data_req  out  DATA_WIDTH  to core
controller_addr_req  out  ADDR_WIDTH  to core
controller_operation_req  out  1  to core
controller_restart_req  out  1  to core
controller_valid_req  out  1  to core
error_signal  out  1  to core; one-cycle abort pulse
controller_data_rsp  in  DATA_WIDTH  read byte from core
scl_in  in  1  observed SCL line
sda_in  in  1  observed SDA line
busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- One clock domain, clk. rst_n is asynchronous, active-low. Reset clears the FIFO, puts the FSM in IDLE, and zeroes every output except cmd_ready, which is 1 after reset. A reset mid-transaction drops controller_valid_req immediately with no response pulse.
- FIFO: cmd_ready = !full (combinational from count). A push happens on cmd_valid && cmd_ready. When push and pop occur in the same cycle the count is unchanged. When full, a pop frees a slot that can only be pushed on the next cycle.
- Bus observation: scl_in and sda_in each pass through a 2-flop synchroniser, then a previous-value register.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - rise = SCL 0 to 1.
- FSM states: IDLE, REQ, XFER, FINISH.
  - IDLE: if the FIFO is non-empty, pop it, latch the entry into the controller_* request registers, set controller_valid_req = 1, go to REQ. This costs 1 cycle from pop to valid.
  - REQ: on START, clear the bit counter (5 bits) and go to XFER.
  - XFER: increment the counter on each rise.
    - On rise 9 (address ACK), if synchronised SDA is 1: NACK. Pulse error_signal, set the latched error flag, clear controller_valid_req, go to FINISH.
    - On rise 18: if restart is latched, complete immediately and go to IDLE; otherwise go to FINISH.
  - FINISH: on STOP, complete and go to IDLE.
- Completion: 1-cycle pulse on rsp_valid.
  - rsp_data = controller_data_rsp sampled that cycle for reads; 0 for writes or on error.
  - rsp_error = latched error flag.
  - controller_valid_req clears on the same edge.
  - A new pop can occur the cycle after returning to IDLE.
- Timeout: the counter counts in REQ, XFER and FINISH, and clears on any synchronised SCL or SDA edge and on state entry. On reaching TIMEOUT_CYCLES:
  - pulse error_signal;
  - rsp_valid = 1 with rsp_error = 1 and rsp_data = 0;
  - clear controller_valid_req;
  - go to IDLE.
  This takes priority over simultaneous bus events.
- A NACK seen on rise 18 (write-data ACK) is not an error. The sequencer does not interpret data ACK; the core owns it.
- controller_restart_req is held from the latched command for the whole transaction.

Decomposition:
- i2c_seq_pkg:
  - FSM state enum;
  - bits-per-transaction constant (18) and address-ACK index constant (9);
  - command struct {op, restart, addr, data}.
- One sub-module: i2c_cmd_fifo, a parameterised synchronous FIFO of the command struct with count, full and empty. The bus edge detector and FSM stay in the top.

Test Plan:
- Write 0xA5 to address 0x10, bus model ACKs everything, then STOP. Required: controller_valid_req high from 1 cycle after the push until the STOP is seen; then rsp_valid = 1, rsp_error = 0, rsp_data = 0x00.
- Read from 0x10, controller_data_rsp = 0x3C, STOP. Required: rsp_data = 0x3C, rsp_error = 0.
- Address NACK (SDA = 1 at rise 9). Required: error_signal pulses for 1 cycle, valid drops; after STOP, rsp_valid = 1 with rsp_error = 1.
- No bus activity after the request, TIMEOUT_CYCLES = 50. Required: at cycle 50 error_signal = 1, rsp_error = 1, FSM back in IDLE.
- Push 5 commands back-to-back at FIFO_DEPTH = 4. Required: cmd_ready drops after the 4th push (the 5th is held by the host), and all 5 complete in order.
- Write with cmd_restart = 1, then a read. Required: the first completes on rise 18 with no STOP; the second request's valid rises 2 cycles later and completes on STOP.
